// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame width and the
// clock-divider derivation. Reused by the receiver, its bus wrapper and the
// transmitter so every block agrees on bit timing.
package uart_pkg;

  localparam int unsigned FRAME_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

  // System clocks per serial bit, rounded down.
  function automatic int unsigned calc_div(input int unsigned freq_mhz,
                                           input int unsigned bauds);
    return (freq_mhz * 1000000) / bauds;
  endfunction

  // Clocks from the start edge to the middle of the start bit.
  function automatic int unsigned calc_half(input int unsigned freq_mhz,
                                            input int unsigned bauds);
    return calc_div(freq_mhz, bauds) / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter for the UART receiver.
//   clk_i      : system clock
//   resetq_i   : synchronous active-low reset, clears the count
//   load_i     : load strobe, takes priority over counting
//   load_val_i : value loaded on load_i
//   zero_o     : count is zero
// The counter stops at zero and is never allowed to wrap; the owner reloads
// it whenever it wants another interval.
module uart_bit_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             resetq_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetq_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, with a single-byte holding register.
//   clk      : system clock, rising edge
//   resetq   : synchronous active-low reset
//   rx       : asynchronous serial line, idles high
//   rd       : consume strobe; clears the held byte and the sticky flags
//   rx_data  : last accepted byte
//   valid    : rx_data holds an unconsumed byte
//   ferr     : sticky framing error (stop bit sampled low)
//   overrun  : sticky, a byte completed while valid was set and was dropped
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ_MHZ = 50,
  parameter int unsigned BAUDS    = 115200
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       ferr,
  output logic       overrun
);

  localparam int unsigned DIV  = calc_div(FREQ_MHZ, BAUDS);
  localparam int unsigned HALF = calc_half(FREQ_MHZ, BAUDS);
  localparam int unsigned TW   = $clog2(DIV);
  localparam int unsigned IW   = $clog2(FRAME_W);

  localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: FREQ_MHZ*1e6/BAUDS must be at least 4");
  end

  // Two-flop synchronizer; resets to the idle (high) line level.
  logic [1:0] sync_q;
  logic       rxs;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rxs = sync_q[1];

  // Bit timer
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  uart_bit_timer #(
    .WIDTH (TW)
  ) u_bit_timer (
    .clk_i      (clk),
    .resetq_i   (resetq),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // FSM
  uart_state_e state_q, state_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic idx_clr, sample, byte_done, frame_err;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!rxs) state_d = ST_START;
      ST_START:     if (tmr_zero) state_d = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:      if (tmr_zero && (bit_idx_q == IW'(FRAME_W - 1))) state_d = ST_STOP;
      ST_STOP:      if (tmr_zero) state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rxs) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load  = 1'b0;
    tmr_val   = DIV_M1;
    idx_clr   = 1'b0;
    sample    = 1'b0;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          tmr_load = 1'b1;
          tmr_val  = HALF_M1;
        end
      end
      ST_START: begin
        if (tmr_zero && !rxs) begin
          tmr_load = 1'b1;
          idx_clr  = 1'b1;
        end
      end
      ST_DATA: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          sample   = 1'b1;
        end
      end
      ST_STOP: begin
        if (tmr_zero) begin
          byte_done = rxs;
          frame_err = !rxs;
        end
      end
      default: ;
    endcase
  end

  // Datapath: bit index and LSB-first shift register
  always_comb begin
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (idx_clr) begin
      bit_idx_d = '0;
    end else if (sample) begin
      bit_idx_d = bit_idx_q + 1'b1;
      shift_d   = {rxs, shift_q[FRAME_W-1:1]};
    end
  end

  // Holding register and sticky flags
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, overrun_q, overrun_d;

  // A completing byte takes precedence over a simultaneous consume: the
  // consume frees the slot for the new byte and leaves overrun untouched.
  always_comb begin
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    overrun_d = overrun_q;
    if (rd) begin
      ferr_d = 1'b0;
    end
    if (byte_done) begin
      if (!valid_q || rd) begin
        rx_data_d = shift_q;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (frame_err) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data = rx_data_q;
  assign valid   = valid_q;
  assign ferr    = ferr_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 MHz / 100000 baud (10 clocks per bit).
module tb_uart_rx;

  localparam int unsigned FREQ_MHZ = 1;
  localparam int unsigned BAUDS    = 100000;
  localparam int unsigned DIV      = FREQ_MHZ * 1000000 / BAUDS;
  localparam int unsigned HALF     = DIV / 2;
  localparam int unsigned LAT      = 2 + HALF + 9 * DIV;

  logic       clk = 1'b0;
  logic       resetq, rx, rd;
  logic [7:0] rx_data;
  logic       valid, ferr, overrun;

  uart_rx #(
    .FREQ_MHZ (FREQ_MHZ),
    .BAUDS    (BAUDS)
  ) dut (
    .clk     (clk),
    .resetq  (resetq),
    .rx      (rx),
    .rd      (rd),
    .rx_data (rx_data),
    .valid   (valid),
    .ferr    (ferr),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned lat_meas = LAT;

  // Reference model of the host-visible holding register
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_rd();
    m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good) m_ferr = 1'b1;
    else if (!m_valid) begin m_data = b; m_valid = 1'b1; end
    else m_ovr = 1'b1;
  endtask

  // Launches on the next rising edge; start bit, 8 data bits LSB first, stop
  // bit at stop_lvl. The line is left at stop_lvl on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx = stop_lvl;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    model_rd();
  endtask

  task automatic test_reset();
    resetq = 1'b0; rx = 1'b1; rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    resetq = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", valid); end
  endtask

  // Latency counted in clock edges after the first edge that samples rx low.
  task automatic test_latency_a5();
    logic seen;
    int unsigned lat;
    seen = 1'b0; lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        for (int n = 1; n <= 200 && !seen; n++) begin
          @(posedge clk); #2;
          if (valid) begin seen = 1'b1; lat = n - 1; end
        end
      end
    join
    model_frame(8'hA5, 1'b1);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL a5_timeout: valid never rose within 200 cycles"); end
    n_checks++;
    if (lat + 1 < LAT || lat > LAT + 1) begin
      n_fail++; $display("FAIL a5_latency: got %0d want %0d +-1", lat, LAT);
    end else lat_meas = lat;
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h want a5", rx_data); end
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL a5_ferr: got %b want 0", ferr); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL a5_overrun: got %b want 0", overrun); end
    pulse_rd();
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL a5_rd_valid: got %b want 0", valid); end
  endtask

  task automatic test_glitch();
    logic any;
    logic [7:0] b;
    any = 1'b0;
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    for (int n = 0; n < 150; n++) begin
      @(posedge clk); #1;
      if (valid || ferr || overrun) any = 1'b1;
    end
    n_checks++; if (any !== 1'b0) begin n_fail++; $display("FAIL glitch_flags: got %b want 0", any); end
    b = 8'($urandom);
    send_frame(b, 1'b1);
    model_frame(b, 1'b1);
    n_checks++; if (rx_data !== m_data) begin n_fail++; $display("FAIL glitch_next_data: got %h want %h", rx_data, m_data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL glitch_next_valid: got %b want 1", valid); end
    pulse_rd();
  endtask

  task automatic test_framing_error();
    logic any;
    any = 1'b0;
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    n_checks++; if (ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", ferr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b want 0", valid); end
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (valid) any = 1'b1;
    end
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (any !== 1'b0) begin n_fail++; $display("FAIL break_valid: got %b want 0", any); end
    n_checks++; if (ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b want 1", ferr); end
    n_checks++; if (rx_data !== m_data) begin n_fail++; $display("FAIL ferr_data_hold: got %h want %h", rx_data, m_data); end
    pulse_rd();
    #1;
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", ferr); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h11, 1'b1);
    model_frame(8'h22, 1'b1);
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data: got %h want 11", rx_data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    pulse_rd();
    #1;
    n_checks++; if ({valid, ferr, overrun} !== 3'b000) begin n_fail++; $display("FAIL ovr_rd_flags: got %b want 000", {valid, ferr, overrun}); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_rd_data_hold: got %h want 11", rx_data); end
  endtask

  // rd is held across exactly the edge that samples the stop bit of 8'h22,
  // which is one edge before valid would rise.
  task automatic test_back_to_back_rd();
    send_frame(8'h11, 1'b1);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", valid); end
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (lat_meas - 1) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    m_data = 8'h22; m_valid = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0;
    n_checks++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL b2b_data: got %h want 22", rx_data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    pulse_rd();
  endtask

  task automatic test_reset_midframe();
    logic any;
    any = 1'b0;
    send_frame(8'h96, 1'b1);
    model_frame(8'h96, 1'b1);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", valid); end
    // 8'hFF by hand: start bit, bits 0..3, then halfway into bit 4
    @(posedge clk); #1 rx = 1'b0;
    repeat (DIV) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4 * DIV + HALF) @(posedge clk);
    #1 resetq = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++; if ({rx_data, valid, ferr, overrun} !== 11'h000) begin n_fail++; $display("FAIL mid_reset_outputs: got %h want 000", {rx_data, valid, ferr, overrun}); end
    resetq = 1'b1;
    for (int n = 0; n < 8 * DIV; n++) begin
      @(posedge clk); #1;
      if (valid || ferr || overrun || rx_data != 8'h00) any = 1'b1;
    end
    n_checks++; if (any !== 1'b0) begin n_fail++; $display("FAIL mid_after_reset: got %b want 0", any); end
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL mid_5a_data: got %h want 5a", rx_data); end
    n_checks++; if ({valid, ferr, overrun} !== 3'b100) begin n_fail++; $display("FAIL mid_5a_flags: got %b want 100", {valid, ferr, overrun}); end
    pulse_rd();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic good;
    for (int it = 0; it < 12; it++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) pulse_rd();
      send_frame(b, good);
      model_frame(b, good);
      if (!good) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        #1 rx = 1'b1;
      end
      repeat ($urandom_range(4, 20)) @(posedge clk);
      #1;
      n_checks++; if (rx_data !== m_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", it, rx_data, m_data); end
      n_checks++; if (valid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", it, valid, m_valid); end
      n_checks++; if (ferr !== m_ferr) begin n_fail++; $display("FAIL rand_ferr[%0d]: got %b want %b", it, ferr, m_ferr); end
      n_checks++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rand_overrun[%0d]: got %b want %b", it, overrun, m_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_latency_a5();
    test_glitch();
    test_framing_error();
    test_overrun();
    test_back_to_back_rd();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter FREQ_MHZ, default 50: system clock frequency in MHz.
REQ-002 Parameter BAUDS, default 115200: serial bit rate.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 resetq  input  1  reset; synchronous and active-low.
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 rd  input  1  consume strobe from the bus wrapper; clears the held byte and its flags.
REQ-007 rx_data  output  8  last accepted byte.
REQ-008 valid  output  1  rx_data holds an unconsumed byte.
REQ-009 ferr  output  1  sticky framing error: stop bit sampled low.
REQ-010 overrun  output  1  sticky: a byte completed while valid=1 and was dropped.

Function
REQ-011 DIV = FREQ_MHZ*1000000/BAUDS, integer floor; HALF = DIV/2; DIV >= 4 required, violation flagged at elaboration.
REQ-012 rx passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: rxs==0 -> START, bit timer loaded with HALF-1.
REQ-015 START: timer==0 and rxs==1 -> IDLE (glitch rejected, no flags); timer==0 and rxs==0 -> DATA, timer=DIV-1, bit index=0.
REQ-016 DATA: each timer==0 samples rxs into shift register LSB-first, reloads DIV-1; after 8th sample -> STOP.
REQ-017 STOP: timer==0 and rxs==1 -> byte complete, -> IDLE; timer==0 and rxs==0 -> ferr<=1, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: stays until rxs==1, then -> IDLE (a held break never yields bytes).
REQ-019 Byte complete with valid==0, or valid==1 and rd in same cycle: rx_data<=shift, valid<=1 next cycle, overrun unchanged.
REQ-020 Byte complete with valid==1 and no rd: rx_data and valid unchanged, overrun<=1.
REQ-021 rd with no byte completing: valid, ferr, overrun <=0 next cycle; rx_data holds.
REQ-022 rd with valid==0: clears ferr/overrun only; no other effect.
REQ-023 Latency: valid rises one cycle after the stop-bit sample, i.e. 2 + HALF + 9*DIV cycles after rx falls (+-1).
REQ-024 Timer is a down-counter of width clog2(DIV); never wraps, always reloaded at 0.

Reset
REQ-025 resetq==0 at a clock edge: state=IDLE, timer=0, bit index=0, shift=0, rx_data=8'h00, valid=0, ferr=0, overrun=0, sync flops=1.
REQ-026 Reset mid-frame aborts the frame; the partial byte is never delivered. A following frame whose start edge occurs after release is received normally.

Structure
REQ-027 Shared package uart_pkg holds the FSM state encoding, the DIV/HALF derivation, and the 8-bit frame width constant; the bus wrapper and a future transmitter reuse it.
REQ-028 One sub-module, uart_bit_timer (load value, load strobe, zero flag), instantiated once; everything else in uart_rx.

Verification (FREQ_MHZ=1, BAUDS=100000 -> DIV=10, HALF=5)
REQ-029 Send 8'hA5, 8N1, 10 cycles/bit -> valid=1 with rx_data=8'hA5 at 2+5+90 cycles (+-1) after start edge; ferr=0, overrun=0.
REQ-030 rx low for 3 cycles then high -> FSM returns to IDLE; valid, ferr, overrun stay 0.
REQ-031 Send 8'h3C with stop bit low -> ferr=1, valid=0; rx held low 50 more cycles produces nothing; rd -> ferr=0.
REQ-032 Send 8'h11 then 8'h22 without rd -> rx_data=8'h11, valid=1, overrun=1; rd -> all flags 0.
REQ-033 Send 8'h11; assert rd on exactly the completion cycle of the next byte 8'h22 -> rx_data=8'h22, valid=1, overrun=0.
REQ-034 Assert resetq=0 for one cycle during bit 4 of 8'hFF, then send 8'h5A -> only 8'h5A delivered; all outputs 0 during and right after reset.
